// File: rtl/scan_test_controller_pkg.sv
// Shared definitions for the scan test controller: default chain length and
// the controller state encoding.
package scan_test_controller_pkg;

  localparam int CHAIN_LEN_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/scan_bit_counter.sv
// Modulo-MODULO bit counter with synchronous clear, count enable and a
// terminal-count flag marking the last bit position of a shift phase.
module scan_bit_counter #(
  parameter int  MODULO = 8,
  localparam int CW     = $clog2(MODULO)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] count_o,
  output logic          tc_o
);

  logic [CW-1:0] count_q;

  assign tc_o    = (count_q == CW'(MODULO - 1));
  assign count_o = count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= tc_o ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/scan_test_controller.sv
// Scan test sequencer: shifts a pattern into a scan chain MSB first, pulses
// one capture cycle, unloads the response and compares it with a golden value.
module scan_test_controller
  import scan_test_controller_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic                 scan_out,
  output logic                 scan_in,
  output logic                 scan_en,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] response
);

  localparam int CW = $clog2(CHAIN_LEN);

  state_e               state_q;
  logic [CHAIN_LEN-1:0] pattern_q;
  logic [CHAIN_LEN-1:0] expected_q;
  logic [CHAIN_LEN-1:0] unload_q;
  logic [CHAIN_LEN-1:0] unload_d;
  logic [CHAIN_LEN-1:0] response_q;
  logic                 pass_q;

  logic [CW-1:0] bit_cnt;
  logic          cnt_tc;
  logic          cnt_clr;
  logic          cnt_en;

  // Counter restarts at every phase boundary so each shift phase sees 0..N-1.
  assign cnt_clr = ((state_q == ST_IDLE) && start)
                || ((state_q == ST_LOAD) && cnt_tc)
                ||  (state_q == ST_CAPTURE);
  assign cnt_en  = (state_q == ST_LOAD) || (state_q == ST_UNLOAD);

  scan_bit_counter #(
    .MODULO (CHAIN_LEN)
  ) u_bit_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (bit_cnt),
    .tc_o    (cnt_tc)
  );

  // First unloaded bit ends up in the MSB after CHAIN_LEN shifts.
  assign unload_d = {unload_q[CHAIN_LEN-2:0], scan_out};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pattern_q  <= '0;
      expected_q <= '0;
      unload_q   <= '0;
      response_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pattern_q  <= pattern;
            expected_q <= expected;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (cnt_tc) state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          state_q <= ST_UNLOAD;
        end
        ST_UNLOAD: begin
          unload_q <= unload_d;
          if (cnt_tc) begin
            response_q <= unload_d;
            pass_q     <= (unload_d == expected_q);
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Chain controls are pure decodes of registered state, counter and pattern.
  always_comb begin
    // NOTE: defaults first so no path through the block leaves an output
    // unassigned, which would otherwise infer a latch.
    scan_en = 1'b0;
    scan_in = 1'b0;
    case (state_q)
      ST_LOAD: begin
        scan_en = 1'b1;
        scan_in = pattern_q[CW'(CHAIN_LEN - 1) - bit_cnt];
      end
      ST_UNLOAD: begin
        scan_en = 1'b1;
      end
      default: begin
        scan_en = 1'b0;
        scan_in = 1'b0;
      end
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign pass     = pass_q;
  assign response = response_q;

endmodule

// File: doc/scan_test_controller.md
SCAN_TEST_CONTROLLER -- requirements
Module: scan_test_controller

Interface
REQ-001 Parameter CHAIN_LEN, default 8: number of scan flip-flops in the attached chain.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request one load/capture/unload test; sampled only in IDLE.
REQ-005 pattern  input  CHAIN_LEN  stimulus to shift into the chain; latched on start acceptance.
REQ-006 expected  input  CHAIN_LEN  golden response; latched on start acceptance.
REQ-007 scan_out  input  1  serial output of the chain under test.
REQ-008 scan_in  output  1  serial data to the chain.
REQ-009 scan_en  output  1  1 = chain shifts, 0 = chain captures functional data.
REQ-010 busy  output  1  high from start acceptance until the DONE cycle inclusive.
REQ-011 done  output  1  one-cycle pulse when the test completes.
REQ-012 pass  output  1  response == expected; valid from done until the next start acceptance.
REQ-013 response  output  CHAIN_LEN  unloaded chain contents; valid from done until the next start acceptance.

Function
REQ-014 FSM states: IDLE, LOAD, CAPTURE, UNLOAD, DONE; one-hot or binary encoding is free.
REQ-015 IDLE: start=1 at the rising edge -> latch pattern and expected, clear bit counter, go to LOAD; start=0 -> stay.
REQ-016 LOAD: CHAIN_LEN cycles; in cycle k (k=0..CHAIN_LEN-1) the block drives scan_en=1 and scan_in=pattern[CHAIN_LEN-1-k] (MSB first); after the last cycle, go to CAPTURE.
REQ-017 CAPTURE: exactly 1 cycle; the block drives scan_en=0 and scan_in=0; then go to UNLOAD.
REQ-018 UNLOAD: CHAIN_LEN cycles; the block drives scan_en=1 and scan_in=0, and samples scan_out at the edge ending cycle k into response[CHAIN_LEN-1-k]; after the last cycle, go to DONE.
REQ-019 DONE: 1 cycle with done=1; pass and response are updated by the edge entering DONE; then return to IDLE.
REQ-020 Latency: start accepted at edge E0; done is high in the cycle after edge E0+2*CHAIN_LEN+1, i.e. 18 cycles after E0 for CHAIN_LEN=8.
REQ-021 scan_en and scan_in are decoded only from registered state, counter and pattern, so they are glitch-free within a cycle.
REQ-022 The bit counter is $clog2(CHAIN_LEN) wide, counts 0..CHAIN_LEN-1, and clears on every LOAD->CAPTURE and CAPTURE->UNLOAD transition; it never wraps past CHAIN_LEN-1.
REQ-023 start while busy is ignored; the latched pattern and expected values do not change mid-test.
REQ-024 start held high through DONE starts a new test at the edge leaving IDLE, one cycle after DONE.
REQ-025 pattern and expected inputs may change freely while busy without effect.

Reset
REQ-026 Asserting rst_n low forces, asynchronously and at any time including mid-LOAD or mid-UNLOAD: state=IDLE, counter=0, scan_en=0, scan_in=0, busy=0, done=0, pass=0, response=0, latched pattern and expected=0.
REQ-027 After reset deassertion, the first start is accepted on the first rising edge at which it is high.

Structure
REQ-028 The shared package/include holds the state encoding constants and the CHAIN_LEN default.
REQ-029 One sub-module, scan_bit_counter (parameterised modulo-CHAIN_LEN counter with clear, enable and terminal-count outputs), is instantiated once.
REQ-030 The bench connects the block to the team's Scan_Chain_Design; pattern[7:4] = multiplicand a and pattern[3:0] = multiplier b, and the captured product appears in response[7:0].

Verification
REQ-031 Reset, then start with pattern=8'h35, expected=8'h0F -> scan_en high for 8 cycles, low for 1, high for 8; done 18 cycles after acceptance; response=8'h0F, pass=1.
REQ-032 pattern=8'hFF, expected=8'hE1 -> response=8'hE1, pass=1; then pattern=8'h23, expected=8'h07 -> response=8'h06, pass=0.
REQ-033 start pulsed again in the 5th LOAD cycle with a different pattern -> ignored; the original test completes with unchanged timing and result.
REQ-034 rst_n low in the 3rd UNLOAD cycle -> all outputs 0 immediately (asynchronous); after release, the test with pattern=8'h35 passes.
REQ-035 start held high continuously -> back-to-back tests, one done pulse every 19 cycles, busy low for exactly one cycle between tests.
REQ-036 Run with CHAIN_LEN=4 against a 4-flip-flop shift-only model -> shift 4, capture 1, unload 4; done 10 cycles after acceptance.
